// File: rtl/model_clock_pkg.sv
// Shared types for the multi-channel model-clock generator: mode encoding,
// per-channel FSM states and a channel-select width helper.
package model_clock_pkg;

  typedef enum logic [1:0] {
    MODE_STOP  = 2'd0,
    MODE_RUN   = 2'd1,
    MODE_STEP  = 2'd2,
    MODE_GATED = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/model_clock_gen_if.sv
// Configuration bus of the model-clock generator: one-cycle write strobe
// carrying target channel, mode and half-period.
interface model_clock_gen_if
  import model_clock_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int DIV_W = 32
);
  localparam int CH_W = ch_width(N_CH);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  mode_t            cfg_mode;
  logic [DIV_W-1:0] cfg_half;

  modport master (output cfg_we, cfg_ch, cfg_mode, cfg_half);
  modport slave  (input  cfg_we, cfg_ch, cfg_mode, cfg_half);

endinterface

// File: rtl/model_clock_channel.sv
// One model-clock channel: HALT/HIGH/LOW FSM, phase counter, shadowed
// half-period and a one-deep single-step request latch.
module model_clock_channel
  import model_clock_pkg::*;
#(
  parameter int DIV_W        = 32,
  parameter int DEFAULT_HALF = 33554432
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  mode_t            mode,
  input  logic [DIV_W-1:0] half,
  input  logic             step,
  input  logic             gate,
  output logic             clk_out,
  output logic             tick,
  output logic             running
);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] half_act_q, half_act_d;
  logic [DIV_W-1:0] half_shadow_q, half_shadow_d;
  mode_t            mode_q, mode_d;
  logic             step_pend_q, step_pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;

  logic [DIV_W-1:0] half_clamped;
  logic             run_ok;
  logic             phase_end;
  logic             start;
  mode_t            mode_next;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    half_act_d    = half_act_q;
    half_shadow_d = half_shadow_q;
    mode_d        = mode_q;
    step_pend_d   = step_pend_q;
    clk_out_d     = clk_out_q;
    tick_d        = 1'b0;
    start         = 1'b0;

    half_clamped = (half == '0) ? DIV_W'(1) : half;
    run_ok = (mode_q == MODE_RUN)
          || (mode_q == MODE_STEP  && step_pend_q)
          || (mode_q == MODE_GATED && gate);
    phase_end = (cnt_q == half_act_q - DIV_W'(1));

    // Phases always run to completion; the run condition is only consulted
    // in HALT and at the end of LOW, so mode changes never cause runt pulses.
    unique case (state_q)
      HALT: start = run_ok;
      HIGH: begin
        if (phase_end) begin
          state_d    = LOW;
          clk_out_d  = 1'b0;
          cnt_d      = '0;
          half_act_d = half_shadow_q;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      LOW: begin
        if (phase_end) begin
          if (run_ok) begin
            start = 1'b1;
          end else begin
            state_d   = HALT;
            clk_out_d = 1'b0;
            cnt_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = HALT;
    endcase

    if (start) begin
      state_d     = HIGH;
      clk_out_d   = 1'b1;
      tick_d      = 1'b1;
      cnt_d       = '0;
      step_pend_d = 1'b0;
    end

    if (wr) begin
      mode_d        = mode;
      half_shadow_d = half_clamped;
      if (state_q == HALT) half_act_d = half_clamped;
    end

    // The mode being written this cycle decides whether a coincident step counts.
    mode_next = wr ? mode : mode_q;
    if (step && mode_next == MODE_STEP && !step_pend_q) step_pend_d = 1'b1;

    running_d = (state_d != HALT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: every register here is reset; the design holds no memory arrays that could skip it.
    if (rst) begin
      state_q       <= HALT;
      cnt_q         <= '0;
      half_act_q    <= DIV_W'(DEFAULT_HALF);
      half_shadow_q <= DIV_W'(DEFAULT_HALF);
      mode_q        <= MODE_RUN;
      step_pend_q   <= 1'b0;
      clk_out_q     <= 1'b0;
      tick_q        <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      half_act_q    <= half_act_d;
      half_shadow_q <= half_shadow_d;
      mode_q        <= mode_d;
      step_pend_q   <= step_pend_d;
      clk_out_q     <= clk_out_d;
      tick_q        <= tick_d;
      running_q     <= running_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign running = running_q;

endmodule

// File: rtl/model_clock_gen.sv
// Multi-channel model-clock generator; channel 0 drives the core's model-clock
// input, the others drive LEDs and debug pins.
module model_clock_gen
  import model_clock_pkg::*;
#(
  parameter int N_CH         = 2,
  parameter int DIV_W        = 32,
  parameter int DEFAULT_HALF = 33554432
) (
  input  logic              clk,
  input  logic              rst,
  model_clock_gen_if.slave  cfg,
  input  logic [N_CH-1:0]   step,
  input  logic [N_CH-1:0]   gate,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   running
);

  logic [N_CH-1:0] wr;

  // Writes addressed beyond the last channel match no decode bit and are dropped.
  always_comb begin
    wr = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr[i] = cfg.cfg_we && (int'(cfg.cfg_ch) == i);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    model_clock_channel #(
      .DIV_W        (DIV_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr[g]),
      .mode    (cfg.cfg_mode),
      .half    (cfg.cfg_half),
      .step    (step[g]),
      .gate    (gate[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g]),
      .running (running[g])
    );
  end

endmodule
